// File: rtl/bram_mp_pkg.sv
// Shared types and helpers for the bram_mp multi-port operand/scratch RAM.
package bram_pkg;

  // Controller state: CLEAR while the zeroing sweep runs, IDLE once accesses are accepted.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } bram_state_t;

  // Datapath width the merge helper is built for; the top's WIDTH must match it.
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  // Replace the bytes of old_word selected by be with the matching bytes of new_word.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_word,
                                                   input logic [DATA_W-1:0] new_word,
                                                   input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/bram_mp_if.sv
// Access bundle for bram_mp: read ports, write ports, ready and collision status.
interface bram_mp_if #(
  parameter int WIDTH           = 32,
  parameter int DEPTH           = 10,
  parameter int MEM_READ_PORTS  = 2,
  parameter int MEM_WRITE_PORTS = 2
);
  logic [MEM_READ_PORTS-1:0]            rd_en;
  logic [DEPTH*MEM_READ_PORTS-1:0]      addr_read;
  logic [WIDTH*MEM_READ_PORTS-1:0]      rd_o;
  logic [MEM_READ_PORTS-1:0]            rd_valid;
  logic [MEM_WRITE_PORTS-1:0]           w_en;
  logic [DEPTH*MEM_WRITE_PORTS-1:0]     addr_write;
  logic [WIDTH*MEM_WRITE_PORTS-1:0]     data;
  logic [(WIDTH/8)*MEM_WRITE_PORTS-1:0] w_be;
  logic                                 ready;
  logic                                 w_collision;

  // Requester side (vector register / load-store path).
  modport master (
    output rd_en, addr_read, w_en, addr_write, data, w_be,
    input  rd_o, rd_valid, ready, w_collision
  );

  // Memory side.
  modport slave (
    input  rd_en, addr_read, w_en, addr_write, data, w_be,
    output rd_o, rd_valid, ready, w_collision
  );
endinterface

// File: rtl/bram_clear_fsm.sv
// Clear-sweep controller: zeroes every entry once after reset, then reports ready.
module bram_clear_fsm
  import bram_pkg::*;
#(
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  output logic             clr_we,
  output logic [DEPTH-1:0] clr_addr
);

  localparam logic [DEPTH:0] LAST = (DEPTH+1)'((1 << DEPTH) - 1);

  bram_state_t    state_q, state_d;
  logic [DEPTH:0] cnt_q, cnt_d;

  // Next-state, sweep counter and clear-write strobe.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we   = 1'b0;
    clr_addr = cnt_q[DEPTH-1:0];
    ready    = (state_q == IDLE);
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = IDLE;
      end
      IDLE:    ;
      default: state_d = CLEAR;
    endcase
  end

  // State and counter registers; reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/bram_mp.sv
// Multi-port RAM with byte enables, lowest-port-wins write priority, registered reads
// and optional write-first bypass on same-address read-during-write.
module bram_mp
  import bram_pkg::*;
#(
  parameter int WIDTH           = DATA_W,
  parameter int DEPTH           = 10,
  parameter int MEM_READ_PORTS  = 2,
  parameter int MEM_WRITE_PORTS = 2,
  parameter int WRITE_FIRST     = 1
) (
  input logic      clk,
  input logic      rst,
  bram_mp_if.slave bus
);

  localparam int ENTRIES = 1 << DEPTH;
  localparam int BEW     = WIDTH / 8;

  logic             ready;
  logic             clr_we;
  logic [DEPTH-1:0] clr_addr;

  bram_clear_fsm #(.DEPTH(DEPTH)) u_clear (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic [WIDTH-1:0] mem [ENTRIES];

  logic [DEPTH-1:0] wa  [MEM_WRITE_PORTS];
  logic [WIDTH-1:0] wd  [MEM_WRITE_PORTS];
  logic [BEW-1:0]   wbe [MEM_WRITE_PORTS];
  logic [DEPTH-1:0] ra  [MEM_READ_PORTS];

  logic [MEM_WRITE_PORTS-1:0] w_win;
  logic                       collision;

  logic [WIDTH-1:0]          rd_data_q [MEM_READ_PORTS];
  logic [WIDTH-1:0]          rd_data_d [MEM_READ_PORTS];
  logic [MEM_READ_PORTS-1:0] rd_valid_q, rd_valid_d;
  logic                      w_collision_q, w_collision_d;

  // Unpack the flat port vectors into per-port fields.
  always_comb begin
    for (int q = 0; q < MEM_WRITE_PORTS; q++) begin
      wa[q]  = bus.addr_write[q*DEPTH +: DEPTH];
      wd[q]  = bus.data[q*WIDTH +: WIDTH];
      wbe[q] = bus.w_be[q*BEW +: BEW];
    end
    for (int p = 0; p < MEM_READ_PORTS; p++) ra[p] = bus.addr_read[p*DEPTH +: DEPTH];
  end

  // Write priority: a port loses to any lower-index enabled port on the same address.
  always_comb begin
    w_win     = '0;
    collision = 1'b0;
    for (int q = 0; q < MEM_WRITE_PORTS; q++) begin
      w_win[q] = bus.w_en[q];
      for (int p = 0; p < q; p++) begin
        if (bus.w_en[p] && bus.w_en[q] && (wa[p] == wa[q])) begin
          w_win[q]  = 1'b0;
          collision = 1'b1;
        end
      end
    end
  end

  // Array update: the clear sweep owns the array until ready, then the winning write ports.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; the sweep zeroes it one entry per cycle instead.
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (ready && !rst) begin
      for (int q = 0; q < MEM_WRITE_PORTS; q++) begin
        if (w_win[q]) mem[wa[q]] <= byte_merge(mem[wa[q]], wd[q], wbe[q]);
      end
    end
  end

  // Read data selection including the write-first bypass; idle ports hold their data.
  always_comb begin
    w_collision_d = ready && collision;
    for (int p = 0; p < MEM_READ_PORTS; p++) begin
      rd_valid_d[p] = ready && bus.rd_en[p];
      rd_data_d[p]  = rd_data_q[p];
      if (rd_valid_d[p]) begin
        rd_data_d[p] = mem[ra[p]];
        if (WRITE_FIRST != 0) begin
          for (int q = 0; q < MEM_WRITE_PORTS; q++) begin
            if (w_win[q] && (wa[q] == ra[p])) rd_data_d[p] = byte_merge(mem[ra[p]], wd[q], wbe[q]);
          end
        end
      end
    end
  end

  // Read registers and collision pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q    <= '0;
      w_collision_q <= 1'b0;
      for (int p = 0; p < MEM_READ_PORTS; p++) rd_data_q[p] <= '0;
    end else begin
      rd_valid_q    <= rd_valid_d;
      w_collision_q <= w_collision_d;
      for (int p = 0; p < MEM_READ_PORTS; p++) rd_data_q[p] <= rd_data_d[p];
    end
  end

  // Drive the outward-facing bundle.
  always_comb begin
    bus.rd_o        = '0;
    bus.rd_valid    = rd_valid_q;
    bus.ready       = ready;
    bus.w_collision = w_collision_q;
    for (int p = 0; p < MEM_READ_PORTS; p++) bus.rd_o[p*WIDTH +: WIDTH] = rd_data_q[p];
  end

endmodule

// File: tb/tb_bram_mp.sv
// Bench for bram_mp: one write-first and one read-first instance share directed stimulus;
// a behavioural model predicts every output each cycle, plus literal spot checks.
module tb_bram_mp;
  localparam int D  = 4;
  localparam int N  = 1 << D;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]   rd_en;
  logic [2*D-1:0] addr_read;
  logic [1:0]   w_en;
  logic [2*D-1:0] addr_write;
  logic [2*W-1:0] data;
  logic [7:0]   w_be;

  bram_mp_if #(.WIDTH(W), .DEPTH(D)) bus1 ();
  bram_mp_if #(.WIDTH(W), .DEPTH(D)) bus0 ();

  assign bus1.rd_en = rd_en;  assign bus1.addr_read = addr_read;
  assign bus1.w_en  = w_en;   assign bus1.addr_write = addr_write;
  assign bus1.data  = data;   assign bus1.w_be = w_be;
  assign bus0.rd_en = rd_en;  assign bus0.addr_read = addr_read;
  assign bus0.w_en  = w_en;   assign bus0.addr_write = addr_write;
  assign bus0.data  = data;   assign bus0.w_be = w_be;

  bram_mp #(.WIDTH(W), .DEPTH(D), .WRITE_FIRST(1)) dut_wf1 (.clk(clk), .rst(rst), .bus(bus1));
  bram_mp #(.WIDTH(W), .DEPTH(D), .WRITE_FIRST(0)) dut_wf0 (.clk(clk), .rst(rst), .bus(bus0));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem   [N];
  logic [31:0] nxt_mem [N];
  bit          claimed [N];
  int          clear_left;
  bit          started = 0;
  logic        exp_ready, exp_coll;
  logic [1:0]  exp_valid;
  logic [31:0] exp_rd1 [2];
  logic [31:0] exp_rd0 [2];
  bit          coll;
  logic [31:0] mask;
  int          a;

  // At each falling edge: compare what the last rising edge produced, then predict the next one.
  always @(negedge clk) begin
    if (started) begin
      check("wf1_ready", {31'd0, bus1.ready}, {31'd0, exp_ready});
      check("wf0_ready", {31'd0, bus0.ready}, {31'd0, exp_ready});
      check("wf1_coll", {31'd0, bus1.w_collision}, {31'd0, exp_coll});
      check("wf0_coll", {31'd0, bus0.w_collision}, {31'd0, exp_coll});
      for (int p = 0; p < 2; p++) begin
        check($sformatf("wf1_valid%0d", p), {31'd0, bus1.rd_valid[p]}, {31'd0, exp_valid[p]});
        check($sformatf("wf0_valid%0d", p), {31'd0, bus0.rd_valid[p]}, {31'd0, exp_valid[p]});
        check($sformatf("wf1_rd%0d", p), bus1.rd_o[p*W +: W], exp_rd1[p]);
        check($sformatf("wf0_rd%0d", p), bus0.rd_o[p*W +: W], exp_rd0[p]);
      end
    end
    if (rst) begin
      started    = 1;
      clear_left = N;
      foreach (m_mem[i]) m_mem[i] = '0;
      exp_ready = 0; exp_coll = 0; exp_valid = '0;
      exp_rd1[0] = '0; exp_rd1[1] = '0; exp_rd0[0] = '0; exp_rd0[1] = '0;
    end else if (started) begin
      bit active;
      active = (clear_left == 0);
      if (clear_left > 0) clear_left--;
      coll = 0;
      nxt_mem = m_mem;
      foreach (claimed[i]) claimed[i] = 0;
      if (active) begin
        for (int q = 0; q < 2; q++) begin
          if (w_en[q]) begin
            a = int'(addr_write[q*D +: D]);
            if (claimed[a]) coll = 1;
            else begin
              claimed[a] = 1;
              mask = '0;
              for (int b = 0; b < 4; b++) if (w_be[q*4 + b]) mask = mask | (32'hFF << (8 * b));
              nxt_mem[a] = (data[q*W +: W] & mask) | (m_mem[a] & ~mask);
            end
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        exp_valid[p] = active && rd_en[p];
        if (exp_valid[p]) begin
          a = int'(addr_read[p*D +: D]);
          exp_rd1[p] = nxt_mem[a];
          exp_rd0[p] = m_mem[a];
        end
      end
      m_mem     = nxt_mem;
      exp_coll  = coll;
      exp_ready = (clear_left == 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clr_in();
    rd_en = '0; addr_read = '0; w_en = '0; addr_write = '0; data = '0; w_be = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr_in();
  endtask

  task automatic wr(input int q, input int adr, input logic [31:0] d, input logic [3:0] be);
    w_en[q] = 1'b1;
    addr_write[q*D +: D] = adr[D-1:0];
    data[q*W +: W] = d;
    w_be[q*4 +: 4] = be;
  endtask

  task automatic rd(input int p, input int adr);
    rd_en[p] = 1'b1;
    addr_read[p*D +: D] = adr[D-1:0];
  endtask

  task automatic chk_rd(input string nm, input int p, input logic [31:0] e1, input logic [31:0] e0);
    check({nm, "_wf1"}, bus1.rd_o[p*W +: W], e1);
    check({nm, "_wf0"}, bus0.rd_o[p*W +: W], e0);
    check({nm, "_valid"}, {31'd0, bus1.rd_valid[p] & bus0.rd_valid[p]}, 32'd1);
  endtask

  task automatic count_sweep(input string nm, input bit poke);
    int n;
    n = 0;
    while (!bus1.ready && n < 100) begin
      if (poke) begin
        wr(0, 1, 32'hDEADBEEF, 4'hF);
        wr(1, 6, 32'hCAFEF00D, 4'hF);
        rd(0, 1);
      end
      tick();
      n++;
    end
    check(nm, n, 16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_ready", {31'd0, bus1.ready | bus0.ready}, 32'd0);
    check("reset_valid", {30'd0, bus1.rd_valid | bus0.rd_valid}, 32'd0);
    check("reset_rd_o", bus1.rd_o[31:0] | bus1.rd_o[63:32], 32'd0);
    check("reset_coll", {31'd0, bus1.w_collision | bus0.w_collision}, 32'd0);
    count_sweep("sweep_len_initial", 1'b0);

    // Read every entry: all zero, valid one cycle after the request.
    for (int i = 0; i < N; i++) begin
      rd(0, i);
      rd(1, N - 1 - i);
      tick();
      chk_rd("sweep_zero", 0, 32'd0, 32'd0);
    end
    tick();
    check("valid_drop", {30'd0, bus1.rd_valid}, 32'd0);

    // Single-cycle reset pulse, then a second reset at sweep cycle 7 with writes attempted.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wr(0, 1, 32'hDEADBEEF, 4'hF);
      rd(0, 1);
      tick();
      check("sweep_no_valid", {30'd0, bus1.rd_valid}, 32'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_sweep("sweep_len_restart", 1'b1);
    rd(0, 1);
    rd(1, 6);
    tick();
    chk_rd("sweep_write_dropped0", 0, 32'd0, 32'd0);
    chk_rd("sweep_write_dropped1", 1, 32'd0, 32'd0);

    // Byte enables.
    wr(0, 5, 32'hAABBCCDD, 4'b1111);
    tick();
    wr(1, 5, 32'h11223344, 4'b0101);
    tick();
    rd(0, 5);
    tick();
    chk_rd("byte_en", 0, 32'hAA22CC44, 32'hAA22CC44);
    check("model_byte_en", m_mem[5], 32'hAA22CC44);

    // Same-address collision: port 0 wins.
    wr(0, 9, 32'h1, 4'hF);
    wr(1, 9, 32'h2, 4'hF);
    tick();
    check("coll_pulse", {31'd0, bus1.w_collision & bus0.w_collision}, 32'd1);
    rd(1, 9);
    tick();
    chk_rd("coll_winner", 1, 32'h1, 32'h1);
    check("coll_one_cycle", {31'd0, bus1.w_collision | bus0.w_collision}, 32'd0);

    // Collision where the winner has a narrow byte enable: the loser still writes nothing.
    wr(0, 12, 32'h00000033, 4'b0001);
    wr(1, 12, 32'h44444444, 4'b1111);
    tick();
    rd(0, 12);
    tick();
    chk_rd("coll_be_winner", 0, 32'h00000033, 32'h00000033);

    // Different addresses: both stored, no pulse.
    wr(0, 10, 32'h0000000A, 4'hF);
    wr(1, 11, 32'h0000000B, 4'hF);
    tick();
    check("no_coll", {31'd0, bus1.w_collision | bus0.w_collision}, 32'd0);
    rd(0, 10);
    rd(1, 11);
    tick();
    chk_rd("two_writes0", 0, 32'h0A, 32'h0A);
    chk_rd("two_writes1", 1, 32'h0B, 32'h0B);

    // Read-during-write bypass.
    wr(0, 3, 32'h5, 4'hF);
    tick();
    wr(1, 3, 32'h7, 4'hF);
    rd(0, 3);
    tick();
    chk_rd("bypass_full", 0, 32'h7, 32'h5);
    rd(0, 3);
    tick();
    chk_rd("bypass_after", 0, 32'h7, 32'h7);
    wr(0, 3, 32'hFFFFFFFF, 4'b0010);
    rd(1, 3);
    tick();
    chk_rd("bypass_merge", 1, 32'h0000FF07, 32'h7);
    check("hold_port0", bus1.rd_o[31:0], 32'h7);

    // Both ports on the same address, back to back.
    wr(0, 2, 32'h40000000, 4'hF);
    tick();
    rd(0, 2);
    rd(1, 2);
    tick();
    chk_rd("multi_a0", 0, 32'h40000000, 32'h40000000);
    chk_rd("multi_a1", 1, 32'h40000000, 32'h40000000);
    rd(0, 3);
    rd(1, 3);
    tick();
    chk_rd("multi_b0", 0, 32'h0000FF07, 32'h0000FF07);
    chk_rd("multi_b1", 1, 32'h0000FF07, 32'h0000FF07);
    tick();
    check("multi_drop", {30'd0, bus1.rd_valid | bus0.rd_valid}, 32'd0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
